// File: rtl/ne16_package.sv
// Shared types and constants for the NE16 normquant bias/shift stage.
package ne16_package;

    localparam int unsigned NE16_ACCUM_SIZE     = 32;
    localparam int unsigned NE16_NQ_SHIFT_WIDTH = 5;

    localparam logic NE16_QMODE_8  = 1'b0;
    localparam logic NE16_QMODE_32 = 1'b1;

    typedef struct packed {
        logic bias_en;
        logic round_en;
        logic relu_en;
        logic qmode;
    } ctrl_normquant_bias_t;

    // Beat index width; a single-beat bundle still gets a 1-bit index
    function automatic int unsigned nq_beat_width(input int unsigned nbeat);
        return (nbeat > 1) ? $clog2(nbeat) : 1;
    endfunction

endpackage

// File: rtl/ne16_normquant_bias_seq_if.sv
// Bundle-in / beat-out handshake bus of the sequenced normquant stage.
interface ne16_normquant_bias_seq_if
    import ne16_package::*;
#(
    parameter int unsigned NCH   = 32,
    parameter int unsigned NLANE = 8,
    parameter int unsigned ACC   = NE16_ACCUM_SIZE,
    parameter int unsigned QNT   = 32
);
    localparam int unsigned NBEAT = NCH / NLANE;
    localparam int unsigned BW    = nq_beat_width(NBEAT);

    logic                                 in_valid;
    logic                                 in_ready;
    ctrl_normquant_bias_t                 ctrl;
    logic [NCH*ACC-1:0]                   accumulator;
    logic [NCH*ACC-1:0]                   norm_bias;
    logic [NCH*NE16_NQ_SHIFT_WIDTH-1:0]   shift;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [NLANE*QNT-1:0]                 out_data;
    logic [BW-1:0]                        out_beat;
    logic                                 out_last;

    modport master (
        output in_valid, ctrl, accumulator, norm_bias, shift, out_ready,
        input  in_ready, out_valid, out_data, out_beat, out_last
    );

    modport slave (
        input  in_valid, ctrl, accumulator, norm_bias, shift, out_ready,
        output in_ready, out_valid, out_data, out_beat, out_last
    );

endinterface

// File: rtl/ne16_normquant_lane.sv
// One channel of bias add, optional rounding, arithmetic shift, ReLU and saturation.
module ne16_normquant_lane
    import ne16_package::*;
#(
    parameter int unsigned ACC = NE16_ACCUM_SIZE,
    parameter int unsigned QNT = 32
) (
    input  ctrl_normquant_bias_t               ctrl,
    input  logic signed [ACC-1:0]              acc,
    input  logic signed [ACC-1:0]              bias,
    input  logic [NE16_NQ_SHIFT_WIDTH-1:0]     shift,
    output logic [QNT-1:0]                     res_c
);
    // Two guard bits: bias add plus rounding offset can never wrap
    localparam int unsigned SW = ACC + 2;

    localparam logic signed [SW-1:0] S32_MAX = SW'(2147483647);
    localparam logic signed [SW-1:0] S32_MIN = SW'(-64'sd2147483648);
    localparam logic signed [SW-1:0] S8_MAX  = SW'(127);
    localparam logic signed [SW-1:0] S8_MIN  = SW'(-128);
    localparam logic signed [SW-1:0] U8_MAX  = SW'(255);
    localparam logic signed [SW-1:0] ZERO    = SW'(0);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] sat;
    logic signed [31:0]   sat32;

    always_comb begin
        sum = SW'(acc) + (ctrl.bias_en ? SW'(bias) : ZERO);
        if (ctrl.round_en && (shift != '0)) begin
            sum = sum + (SW'(1) << (shift - 1'b1));
        end
        shr = sum >>> shift;
        if (ctrl.relu_en && shr[SW-1]) begin
            shr = ZERO;
        end
        if (ctrl.qmode == NE16_QMODE_8) begin
            hi = ctrl.relu_en ? U8_MAX : S8_MAX;
            lo = ctrl.relu_en ? ZERO : S8_MIN;
        end else begin
            hi = S32_MAX;
            lo = S32_MIN;
        end
        if (shr > hi) begin
            sat = hi;
        end else if (shr < lo) begin
            sat = lo;
        end else begin
            sat = shr;
        end
        // ReLU results are non-negative, so sign extension equals zero extension
        sat32 = 32'(sat);
        res_c = QNT'(sat32);
    end

endmodule

// File: rtl/ne16_normquant_bias_seq.sv
// Latches one accumulator bundle and streams normquant results NLANE channels per beat.
module ne16_normquant_bias_seq
    import ne16_package::*;
#(
    parameter int unsigned NCH   = 32,
    parameter int unsigned NLANE = 8,
    parameter int unsigned ACC   = NE16_ACCUM_SIZE,
    parameter int unsigned QNT   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      clear_i,
    ne16_normquant_bias_seq_if.slave  bus
);
    localparam int unsigned NBEAT = NCH / NLANE;
    localparam int unsigned BW    = nq_beat_width(NBEAT);
    localparam int unsigned SHW   = NE16_NQ_SHIFT_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e               state_q, state_n;
    logic [BW-1:0]        cnt_q, cnt_n;
    ctrl_normquant_bias_t ctrl_q, ctrl_n;
    logic [NCH*ACC-1:0]   acc_q, acc_n;
    logic [NCH*ACC-1:0]   bias_q, bias_n;
    logic [NCH*SHW-1:0]   shift_q, shift_n;
    logic                 in_ready_q, in_ready_n;
    logic                 out_valid_q, out_valid_n;
    logic [NLANE*QNT-1:0] out_data_q, out_data_n;
    logic [BW-1:0]        out_beat_q, out_beat_n;
    logic                 out_last_q, out_last_n;

    logic signed [ACC-1:0] lane_acc   [NLANE];
    logic signed [ACC-1:0] lane_bias  [NLANE];
    logic [SHW-1:0]        lane_shift [NLANE];
    logic [QNT-1:0]        lane_res   [NLANE];
    logic [NLANE*QNT-1:0]  beat_data;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Channel select for the beat addressed by the counter
    always_comb begin
        for (int unsigned l = 0; l < NLANE; l++) begin
            int unsigned ch;
            ch            = 32'(cnt_q) * NLANE + l;
            lane_acc[l]   = acc_q[ch*ACC +: ACC];
            lane_bias[l]  = bias_q[ch*ACC +: ACC];
            lane_shift[l] = shift_q[ch*SHW +: SHW];
        end
    end

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        ne16_normquant_lane #(.ACC(ACC), .QNT(QNT)) u_lane (
            .ctrl  (ctrl_q),
            .acc   (lane_acc[l]),
            .bias  (lane_bias[l]),
            .shift (lane_shift[l]),
            .res_c (lane_res[l])
        );
        assign beat_data[l*QNT +: QNT] = lane_res[l];
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        ctrl_n      = ctrl_q;
        acc_n       = acc_q;
        bias_n      = bias_q;
        shift_n     = shift_q;
        out_valid_n = out_valid_q;
        out_data_n  = out_data_q;
        out_beat_n  = out_beat_q;
        out_last_n  = out_last_q;

        if (clear_i) begin
            state_n     = IDLE;
            cnt_n       = '0;
            out_valid_n = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        ctrl_n  = bus.ctrl;
                        acc_n   = bus.accumulator;
                        bias_n  = bus.norm_bias;
                        shift_n = bus.shift;
                        cnt_n   = '0;
                        state_n = BUSY;
                    end
                end
                BUSY: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_n = 1'b0;
                    end
                    // Reload while the current beat leaves: no bubble under constant ready
                    if (!out_valid_q || bus.out_ready) begin
                        out_valid_n = 1'b1;
                        out_data_n  = beat_data;
                        out_beat_n  = cnt_q;
                        out_last_n  = (cnt_q == LAST_BEAT);
                        if (cnt_q == LAST_BEAT) begin
                            cnt_n   = '0;
                            state_n = DRAIN;
                        end else begin
                            cnt_n = cnt_q + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_n = 1'b0;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        in_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beat_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            ctrl_q      <= ctrl_n;
            acc_q       <= acc_n;
            bias_q      <= bias_n;
            shift_q     <= shift_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            out_beat_q  <= out_beat_n;
            out_last_q  <= out_last_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_beat  = out_beat_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_ne16_normquant_bias_seq.sv
// Scoreboard bench for the sequenced normquant stage: queued expected beats vs streamed output.
module tb_ne16_normquant_bias_seq;
    import ne16_package::*;

    localparam int unsigned NCH   = 32;
    localparam int unsigned NLANE = 8;
    localparam int unsigned ACC   = 32;
    localparam int unsigned QNT   = 32;
    localparam int unsigned NBEAT = NCH / NLANE;
    localparam int unsigned BW    = 2;

    typedef struct {
        logic [NLANE*QNT-1:0] data;
        logic [BW-1:0]        beat;
        logic                 last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_mode = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    ne16_normquant_bias_seq_if #(.NCH(NCH), .NLANE(NLANE), .ACC(ACC), .QNT(QNT)) bus ();

    ne16_normquant_bias_seq #(.NCH(NCH), .NLANE(NLANE), .ACC(ACC), .QNT(QNT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (test_mode),
        .clear_i     (clear),
        .bus         (bus)
    );

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_v  [NCH];
    int          bias_v [NCH];
    int unsigned sh_v   [NCH];
    logic [31:0] exp_ch [NCH];

    // Reference arithmetic in 64-bit integers
    function automatic logic [31:0] model(input int a, input int b, input int unsigned sh,
                                          input ctrl_normquant_bias_t c);
        longint s, hi, lo;
        s = longint'(a) + (c.bias_en ? longint'(b) : 64'sd0);
        if (c.round_en && sh != 0) s = s + (64'sd1 << (sh - 1));
        s = s >>> sh;
        if (c.relu_en && s < 0) s = 0;
        if (c.qmode == NE16_QMODE_8) begin
            hi = c.relu_en ? 255 : 127;
            lo = c.relu_en ? 0 : -128;
        end else begin
            hi = 64'sd2147483647;
            lo = -64'sd2147483648;
        end
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bundle(input ctrl_normquant_bias_t c);
        bit ok = 1'b0;
        exp_t e;
        tick();
        bus.ctrl = c;
        for (int i = 0; i < NCH; i++) begin
            bus.accumulator[i*ACC +: ACC] = acc_v[i];
            bus.norm_bias[i*ACC +: ACC]   = bias_v[i];
            bus.shift[i*5 +: 5]           = sh_v[i][4:0];
        end
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        tick();
        bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL in_handshake: in_ready=%b after 50 cycles, required 1", bus.in_ready);
            return;
        end
        for (int b = 0; b < NBEAT; b++) begin
            for (int l = 0; l < NLANE; l++) e.data[l*QNT +: QNT] = exp_ch[b*NLANE + l];
            e.beat = BW'(b);
            e.last = (b == NBEAT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) return;
        end
        vectors++; miscompares++;
        $display("FAIL %s drain: %0d beats pending, out_valid=%b, required 0 and 0", tag, exp_q.size(), bus.out_valid);
    endtask

    // Pops on every output handshake and checks stability while stalled
    task automatic monitor();
        logic pstall = 1'b0, pclear = 1'b0, pl = 1'b0;
        logic [NLANE*QNT-1:0] pd = '0;
        logic [BW-1:0] pb = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin pstall = 1'b0; continue; end
            if (pstall && !pclear) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_beat !== pb || bus.out_last !== pl) begin
                    miscompares++;
                    $display("FAIL hold: valid=%b beat=%0d last=%b data=%h, required 1 %0d %b %h",
                             bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, pb, pl, pd);
                end
            end
            if (bus.out_valid && bus.out_ready && !clear) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: beat=%0d data=%h, required no beat", bus.out_beat, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e.data || bus.out_beat !== e.beat || bus.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL beat: beat=%0d last=%b data=%h, required %0d %b %h",
                                 bus.out_beat, bus.out_last, bus.out_data, e.beat, e.last, e.data);
                    end
                end
            end
            pstall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pb = bus.out_beat; pl = bus.out_last; pclear = clear;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ctrl = '0;
        bus.accumulator = '0; bus.norm_bias = '0; bus.shift = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_beat !== '0 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b beat=%0d last=%b data=%h, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data);
        end
    endtask

    task automatic test_basic();
        ctrl_normquant_bias_t c = '{bias_en: 1'b1, round_en: 1'b0, relu_en: 1'b0, qmode: NE16_QMODE_32};
        for (int i = 0; i < NCH; i++) begin
            acc_v[i] = 1000; bias_v[i] = 24; sh_v[i] = 2; exp_ch[i] = 32'd256;
        end
        bus.out_ready = 1'b1;
        send_bundle(c);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_t1: out_valid=%b, required 0", bus.out_valid);
        end
        for (int b = 0; b < NBEAT; b++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_beat !== BW'(b) || bus.out_last !== (b == NBEAT - 1)) begin
                miscompares++;
                $display("FAIL stream_t%0d: valid=%b beat=%0d last=%b, required 1 %0d %b",
                         b + 2, bus.out_valid, bus.out_beat, bus.out_last, b, (b == NBEAT - 1));
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_idle: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        wait_empty("basic");
    endtask

    task automatic test_rounding();
        ctrl_normquant_bias_t c = '{bias_en: 1'b0, round_en: 1'b1, relu_en: 1'b0, qmode: NE16_QMODE_32};
        for (int i = 0; i < NCH; i++) begin
            bias_v[i] = 0;
            unique case (i % 4)
                0, 2: begin acc_v[i] = 5;  sh_v[i] = 1; exp_ch[i] = 32'd3; end
                1:    begin acc_v[i] = -5; sh_v[i] = 1; exp_ch[i] = 32'hFFFF_FFFE; end
                default: begin acc_v[i] = 5; sh_v[i] = 0; exp_ch[i] = 32'd5; end
            endcase
        end
        send_bundle(c);
        wait_empty("round_on");
        c.round_en = 1'b0;
        for (int i = 0; i < NCH; i++) begin acc_v[i] = 5; sh_v[i] = 1; exp_ch[i] = 32'd2; end
        send_bundle(c);
        wait_empty("round_off");
    endtask

    task automatic test_saturation();
        ctrl_normquant_bias_t c = '{bias_en: 1'b0, round_en: 1'b0, relu_en: 1'b0, qmode: NE16_QMODE_8};
        for (int i = 0; i < NCH; i++) begin
            bias_v[i] = 12345; sh_v[i] = 4;
            acc_v[i]  = (i % 2 == 0) ? 100000 : -100000;
            exp_ch[i] = (i % 2 == 0) ? 32'd127 : 32'hFFFF_FF80;
        end
        send_bundle(c);
        wait_empty("sat8");
        c.relu_en = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            acc_v[i]  = (i % 2 == 0) ? -100000 : 4000;
            sh_v[i]   = (i % 2 == 0) ? 4 : 2;
            exp_ch[i] = (i % 2 == 0) ? 32'd0 : 32'd255;
        end
        send_bundle(c);
        wait_empty("sat8_relu");
    endtask

    task automatic random_bundle(output ctrl_normquant_bias_t c);
        c = ctrl_normquant_bias_t'($urandom_range(15));
        for (int i = 0; i < NCH; i++) begin
            acc_v[i]  = int'($urandom);
            bias_v[i] = int'($urandom);
            sh_v[i]   = $urandom_range(31);
            exp_ch[i] = model(acc_v[i], bias_v[i], sh_v[i], c);
        end
    endtask

    task automatic test_backpressure();
        ctrl_normquant_bias_t c;
        for (int n = 0; n < 3; n++) begin
            random_bundle(c);
            bus.out_ready = 1'b1;
            send_bundle(c);
            for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.out_valid); k++) begin
                bus.out_ready = (k % 2 == 0);
                tick();
            end
            bus.out_ready = 1'b1;
            wait_empty("backpressure");
        end
    endtask

    task automatic test_clear();
        ctrl_normquant_bias_t c;
        random_bundle(c);
        bus.out_ready = 1'b1;
        send_bundle(c);
        tick();
        tick();
        bus.out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        random_bundle(c);
        send_bundle(c);
        wait_empty("after_clear");
    endtask

    task automatic test_overflow();
        ctrl_normquant_bias_t c = '{bias_en: 1'b1, round_en: 1'b1, relu_en: 1'b0, qmode: NE16_QMODE_32};
        for (int i = 0; i < NCH; i++) begin
            sh_v[i]   = 0;
            acc_v[i]  = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            bias_v[i] = acc_v[i];
            exp_ch[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        send_bundle(c);
        wait_empty("overflow");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_clear();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
